// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages plus flush and occupancy sideband.
// slave = the stage register's view, master = the surrounding pipeline's view.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 134
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: opaque payload, valid/ready handshake, flush inserts a bubble.
// Latency: 1 cycle from accept to out_valid; 1 payload/cycle with out_ready held high.
// Backpressure: SKID=1 holds up to 2 entries with a registered in_ready; SKID=0 holds 1 with in_ready combinational.
module pipe_stage_reg #(
    parameter int                DATA_W = 134,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter bit                SKID   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    pipe_stage_reg_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_nxt;
    logic [DATA_W-1:0] main_q, main_nxt;
    logic [DATA_W-1:0] skid_q, skid_nxt;
    logic              rdy_q;
    logic              out_valid_int;
    logic              in_ready_int;
    logic              acc;
    logic              con;

    assign out_valid_int = (state_q != EMPTY);
    // SKID=0 lets a consume free the slot in the same cycle, so ready follows out_ready directly.
    assign in_ready_int  = SKID ? rdy_q : (!out_valid_int || bus.out_ready);
    assign acc           = bus.in_valid && in_ready_int;
    assign con           = out_valid_int && bus.out_ready;

    always_comb begin
        state_nxt = state_q;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_nxt = ONE;
                        main_nxt  = bus.in_data;
                    end
                end
                ONE: begin
                    if (acc && con) begin
                        main_nxt = bus.in_data;
                    end else if (acc && SKID) begin
                        state_nxt = TWO;
                        skid_nxt  = bus.in_data;
                    end else if (con) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (con) begin
                        state_nxt = ONE;
                        main_nxt  = skid_q;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_nxt;
            main_q  <= main_nxt;
            skid_q  <= skid_nxt;
            rdy_q   <= (state_nxt != TWO);
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_data  = out_valid_int ? main_q : BUBBLE;
    assign bus.occupancy = state_q;
endmodule
